// File: rtl/fixed_point_accumulator_pkg.sv
// Shared constants and types for the inference datapath.
// Q8.8 limits and the accumulator FSM state encoding.
package inference_pkg;

  localparam int VOCAB_SIZE     = 76;
  localparam int EMBEDDING_SIZE = 4;
  localparam int LINEAR_SIZE    = 8;
  localparam int DATA_W         = 16;
  localparam int FRAC_BITS      = 8;

  localparam logic [15:0] Q88_MIN = 16'h8000;
  localparam logic [15:0] Q88_MAX = 16'h7FFF;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Accumulate interface between inference_fsm (master)
// and fixed_point_accumulator (slave).
interface fixed_point_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);

  logic [DATA_W-1:0] accumulator_data;
  logic              accumulator_input_valid;
  logic              accumulator_last;
  logic              accumulator_clear;
  logic [DATA_W-1:0] accumulator_result;
  logic              accumulator_last_valid;
  logic [CNT_W-1:0]  accumulator_terms;
  logic              accumulator_overflow;

  modport master (
    output accumulator_data,
    output accumulator_input_valid,
    output accumulator_last,
    output accumulator_clear,
    input  accumulator_result,
    input  accumulator_last_valid,
    input  accumulator_terms,
    input  accumulator_overflow
  );

  modport slave (
    input  accumulator_data,
    input  accumulator_input_valid,
    input  accumulator_last,
    input  accumulator_clear,
    output accumulator_result,
    output accumulator_last_valid,
    output accumulator_terms,
    output accumulator_overflow
  );

endinterface

// File: rtl/fixed_point_accumulator_q_narrow.sv
// ACC_W -> DATA_W narrowing with out-of-range flag.
// ACCUMULATOR_SATURATE_EN: clamp; otherwise wrap.
module q_narrow #(
  parameter int ACC_W  = 24,
  parameter int DATA_W = 16
) (
  input  logic [ACC_W-1:0]  sum,
  output logic [DATA_W-1:0] q,
  output logic              oor
);

  logic [ACC_W-DATA_W:0] hi;

  assign hi  = sum[ACC_W-1:DATA_W-1];
  assign oor = !((&hi) || !(|hi));

`ifdef ACCUMULATOR_SATURATE_EN
  // Clamp toward the sign of the wide sum when it does not fit.
  always_comb begin
    q = sum[DATA_W-1:0];
    if (oor) begin
      q = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                       : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign q = sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/fixed_point_accumulator.sv
// Signed Q8.8 group accumulator; one narrowed result per group.
// Optional macro ACCUMULATOR_SATURATE_EN selects clamping narrowing.
module fixed_point_accumulator
  import inference_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 8
) (
  input logic                   clk,
  input logic                   reset,
  fixed_point_accumulator_if.slave acc
);

  acc_state_t        state;
  acc_state_t        state_n;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              fresh;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  sum;
  logic              add_ovf;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] narrow_q;
  logic              narrow_oor;
  logic              beat;
  logic              last_beat;

  // The Q point is carried through unchanged by summation.
  logic [31:0] frac_unused;
  assign frac_unused = FRAC_BITS;

  assign beat      = acc.accumulator_input_valid;
  assign last_beat = beat && acc.accumulator_last;

  // A beat starts a new group from IDLE or when clear drops the old sum.
  always_comb begin
    fresh    = (state == IDLE) || acc.accumulator_clear;
    acc_base = fresh ? '0 : acc_q;
    cnt_base = fresh ? '0 : cnt_q;
    term     = {{(ACC_W-DATA_W){acc.accumulator_data[DATA_W-1]}},
                acc.accumulator_data};
    sum      = acc_base + term;
    add_ovf  = (acc_base[ACC_W-1] == term[ACC_W-1]) &&
               (sum[ACC_W-1] != acc_base[ACC_W-1]);
    cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  end

  q_narrow #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W)
  ) u_narrow (
    .sum(sum),
    .q  (narrow_q),
    .oor(narrow_oor)
  );

  // Next-state: a group opens on a non-last beat, closes on last or clear.
  always_comb begin
    state_n = state;
    if (beat) begin
      state_n = acc.accumulator_last ? IDLE : ACCUM;
    end else if (acc.accumulator_clear) begin
      state_n = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Partial sum, term count, result and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q                      <= '0;
      cnt_q                      <= '0;
      acc.accumulator_result     <= '0;
      acc.accumulator_terms      <= '0;
      acc.accumulator_last_valid <= 1'b0;
      acc.accumulator_overflow   <= 1'b0;
    end else begin
      acc.accumulator_last_valid <= last_beat;
      if (beat) begin
        acc_q <= sum;
        cnt_q <= cnt_inc;
        acc.accumulator_overflow <= acc.accumulator_overflow |
                                    add_ovf |
                                    (last_beat & narrow_oor);
        if (acc.accumulator_last) begin
          acc.accumulator_result <= narrow_q;
          acc.accumulator_terms  <= cnt_inc;
        end
      end else if (acc.accumulator_clear) begin
        acc_q                    <= '0;
        cnt_q                    <= '0;
        acc.accumulator_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Scoreboard bench for fixed_point_accumulator.
// Directed groups; monitor compares each strobe against the queue.
module tb_fixed_point_accumulator;

  typedef struct {
    logic [15:0] result;
    logic [7:0]  terms;
    logic        ovf;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  fixed_point_accumulator_if #(.DATA_W(16), .CNT_W(8)) bus ();

  fixed_point_accumulator #(
    .DATA_W   (16),
    .FRAC_BITS(8),
    .ACC_W    (24),
    .CNT_W    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .acc  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a strobe is presented.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.accumulator_last_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, int'(bus.accumulator_result),
              int'(e.result));
        check({e.name, "_terms"}, int'(bus.accumulator_terms),
              int'(e.terms));
        check({e.name, "_ovf"}, int'(bus.accumulator_overflow),
              int'(e.ovf));
      end
    end
  end

  task automatic idle();
    bus.accumulator_data        = '0;
    bus.accumulator_input_valid = 1'b0;
    bus.accumulator_last        = 1'b0;
    bus.accumulator_clear       = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input logic l,
                      input logic c);
    bus.accumulator_data        = d;
    bus.accumulator_input_valid = 1'b1;
    bus.accumulator_last        = l;
    bus.accumulator_clear       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    idle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic [15:0] r, input logic [7:0] t,
                               input logic o, input string n);
    exp_t e;
    e.result = r;
    e.terms  = t;
    e.ovf    = o;
    e.name   = n;
    sb.push_back(e);
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({n, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", int'(bus.accumulator_result), 0);
    check("rst_terms", int'(bus.accumulator_terms), 0);
    check("rst_valid", int'(bus.accumulator_last_valid), 0);
    check("rst_ovf", int'(bus.accumulator_overflow), 0);
    reset = 1'b1;
    gap(2);

    expect_strobe(16'h0200, 8'd3, 1'b0, "t1");
    beat(16'h0100, 1'b0, 1'b0);
    beat(16'h0200, 1'b0, 1'b0);
    beat(16'hFF00, 1'b1, 1'b0);
    gap(2);
    drain("t1");

    expect_strobe(16'h8001, 8'd1, 1'b0, "t2");
    beat(16'h8001, 1'b1, 1'b0);
    gap(2);
    drain("t2");

    expect_strobe(16'h0010, 8'd1, 1'b0, "t3a");
    expect_strobe(16'h0020, 8'd1, 1'b0, "t3b");
    beat(16'h0010, 1'b1, 1'b0);
    beat(16'h0020, 1'b1, 1'b0);
    gap(2);
    drain("t3");

`ifdef ACCUMULATOR_SATURATE_EN
    expect_strobe(16'h7FFF, 8'd2, 1'b1, "t4");
`else
    expect_strobe(16'hE000, 8'd2, 1'b1, "t4");
`endif
    beat(16'h7000, 1'b0, 1'b0);
    beat(16'h7000, 1'b1, 1'b0);
    gap(2);
    drain("t4");
    check("t4_sticky", int'(bus.accumulator_overflow), 1);

    bus.accumulator_clear = 1'b1;
    @(posedge clk);
    #1;
    idle();
    check("clr_ovf", int'(bus.accumulator_overflow), 0);
    gap(1);

    expect_strobe(16'h0005, 8'd1, 1'b0, "t5");
    beat(16'h0100, 1'b0, 1'b0);
    beat(16'h0100, 1'b0, 1'b0);
    beat(16'h0005, 1'b1, 1'b1);
    gap(2);
    drain("t5");

    beat(16'h0100, 1'b0, 1'b0);
    beat(16'h0100, 1'b0, 1'b0);
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("rst2_result", int'(bus.accumulator_result), 0);
    check("rst2_terms", int'(bus.accumulator_terms), 0);
    check("rst2_valid", int'(bus.accumulator_last_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    gap(3);

    bus.accumulator_last = 1'b1;
    @(posedge clk);
    #1;
    idle();
    gap(2);
    check("ign_last_valid", int'(bus.accumulator_last_valid), 0);

    expect_strobe(16'h012C, 8'd255, 1'b0, "t6");
    for (int i = 0; i < 300; i++) begin
      beat(16'h0001, (i == 299), 1'b0);
    end
    gap(2);
    drain("t6");
    gap(4);
    check("t6_hold", int'(bus.accumulator_result), 16'h012C);
    check("t6_hold_valid", int'(bus.accumulator_last_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
